// File: rtl/mem_sweep_gen_pkg.sv
// Shared types and helpers for the strided memory sweep engine.
// Mode/state encodings and window-length arithmetic live here.
package mem_sweep_pkg;

    localparam int ERRCNT_W = 16;

    typedef enum logic [1:0] {
        M_READ  = 2'd0,
        M_FILL  = 2'd1,
        M_CHECK = 2'd2,
        M_WRAP  = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_DRAIN,
        S_FIN
    } state_t;

    function automatic int unsigned sweep_len(
        input int unsigned base,
        input int unsigned limit,
        input int unsigned stride
    );
        if (stride == 0 || limit < base) return 1;
        return (limit - base) / stride + 1;
    endfunction

endpackage

// File: rtl/mem_sweep_gen_addr_ctr.sv
// Strided window address counter shared by the write and read phases.
// Termination is by index, so an unreachable LIMIT truncates cleanly.
module sweep_addr_ctr
    import mem_sweep_pkg::*;
#(
    parameter int          AW     = 32,
    parameter int unsigned BASE   = 0,
    parameter int unsigned LIMIT  = 64,
    parameter int unsigned STRIDE = 4
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam int unsigned N  = sweep_len(BASE, LIMIT, STRIDE);
    localparam int          KW = (N > 1) ? $clog2(N) : 1;

    logic [KW-1:0] k;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            addr <= AW'(BASE);
            k    <= '0;
        end else if (clr) begin
            addr <= AW'(BASE);
            k    <= '0;
        end else if (inc) begin
            addr <= addr + AW'(STRIDE);
            k    <= k + KW'(1);
        end
    end

    assign last = (k == KW'(N - 1));

endmodule

// File: rtl/mem_sweep_gen.sv
// Memory sweep engine: read sweep, pattern fill, fill-then-verify
// and wrapping read over a strided address window.
module mem_sweep_gen
    import mem_sweep_pkg::*;
#(
    parameter int          AW     = 32,
    parameter int          DW     = 32,
    parameter int unsigned BASE   = 0,
    parameter int unsigned LIMIT  = 64,
    parameter int unsigned STRIDE = 4,
    parameter int          RD_LAT = 1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [DW-1:0]       seed,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       raddress,
    output logic [AW-1:0]       waddress,
    output logic                wr,
    output logic [DW-1:0]       datain,
    input  logic [DW-1:0]       dataout,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [AW-1:0]       err_addr
);

    if (LIMIT < BASE) begin : g_bad_window
        $error("mem_sweep_gen: LIMIT must be >= BASE");
    end
    if (STRIDE == 0) begin : g_bad_stride
        $error("mem_sweep_gen: STRIDE must be > 0");
    end
    if (RD_LAT < 1) begin : g_bad_lat
        $error("mem_sweep_gen: RD_LAT must be >= 1");
    end

    localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    function automatic logic [DW-1:0] pat(
        input logic [DW-1:0] s,
        input logic [AW-1:0] a
    );
        return s + DW'(a);
    endfunction

    state_t        state;
    mode_t         mode_q;
    logic [DW-1:0] seed_q;
    logic [DCW-1:0] dcnt;

    logic [AW-1:0] ctr_addr;
    logic [AW-1:0] nxt;
    logic          last;
    logic          ctr_clr;
    logic          ctr_inc;
    logic          go;
    logic          halt;
    logic          is_fill;

    assign go      = (state == S_IDLE) && start && !stop;
    assign halt    = (state != S_IDLE) && stop;
    assign nxt     = ctr_addr + AW'(STRIDE);
    assign is_fill = (mode_t'(mode) == M_FILL) ||
                     (mode_t'(mode) == M_CHECK);

    // Rewind for CHECK's read-back and for every WRAP pass.
    assign ctr_clr = go || (!halt && last &&
                     ((state == S_FILL && mode_q == M_CHECK) ||
                      (state == S_READ && mode_q == M_WRAP)));
    assign ctr_inc = !halt && !last &&
                     (state == S_FILL || state == S_READ);

    sweep_addr_ctr #(
        .AW     (AW),
        .BASE   (BASE),
        .LIMIT  (LIMIT),
        .STRIDE (STRIDE)
    ) u_ctr (
        .clk  (clk),
        .nrst (nrst),
        .clr  (ctr_clr),
        .inc  (ctr_inc),
        .addr (ctr_addr),
        .last (last)
    );

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state    <= S_IDLE;
            mode_q   <= M_READ;
            seed_q   <= '0;
            dcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr       <= 1'b0;
            datain   <= '0;
            raddress <= AW'(BASE);
            waddress <= AW'(BASE);
        end else begin
            done <= 1'b0;
            if (halt) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                wr    <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: if (go) begin
                        mode_q <= mode_t'(mode);
                        seed_q <= seed;
                        busy   <= 1'b1;
                        if (is_fill) begin
                            state    <= S_FILL;
                            wr       <= 1'b1;
                            waddress <= AW'(BASE);
                            datain   <= pat(seed, AW'(BASE));
                        end else begin
                            state    <= S_READ;
                            raddress <= AW'(BASE);
                        end
                    end
                    S_FILL: if (!last) begin
                        waddress <= nxt;
                        datain   <= pat(seed_q, nxt);
                    end else begin
                        wr <= 1'b0;
                        if (mode_q == M_CHECK) begin
                            state    <= S_READ;
                            raddress <= AW'(BASE);
                        end else begin
                            state <= S_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    S_READ: if (!last) begin
                        raddress <= nxt;
                    end else if (mode_q == M_WRAP) begin
                        raddress <= AW'(BASE);
                    end else if (mode_q == M_CHECK) begin
                        state <= S_DRAIN;
                        dcnt  <= '0;
                    end else begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    S_DRAIN: if (dcnt == DCW'(RD_LAT - 1)) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DCW'(1);
                    end
                    S_FIN:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Expected-data pipeline: each entry exits as its read data arrives.
    logic [RD_LAT-1:0] pv;
    logic [DW-1:0]     pe [RD_LAT];
    logic [AW-1:0]     pa [RD_LAT];
    logic              push;
    logic              hit;

    assign push = (state == S_READ) && (mode_q == M_CHECK);
    assign hit  = !halt && pv[RD_LAT-1] &&
                  (dataout != pe[RD_LAT-1]);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            pv        <= '0;
            err       <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pe[i] <= '0;
                pa[i] <= '0;
            end
        end else begin
            if (halt || go) begin
                pv <= '0;
            end else begin
                pv[0] <= push;
                for (int i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
            end
            pe[0] <= pat(seed_q, raddress);
            pa[0] <= raddress;
            for (int i = 1; i < RD_LAT; i++) begin
                pe[i] <= pe[i-1];
                pa[i] <= pa[i-1];
            end
            if (go) begin
                err       <= 1'b0;
                err_count <= '0;
                err_addr  <= '0;
            end else if (hit) begin
                err <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + ERRCNT_W'(1);
                if (!err)
                    err_addr <= pa[RD_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_sweep_gen.sv
// Scoreboard bench for mem_sweep_gen: default instance plus a
// narrow, odd-window, 3-cycle-latency instance.
module tb_mem_sweep_gen;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        a_start = 1'b0, a_stop = 1'b0;
    logic [1:0]  a_mode  = 2'd0;
    logic [31:0] a_seed  = '0;
    logic        a_busy, a_done, a_wr, a_err;
    logic [31:0] a_ra, a_wa, a_din, a_ea;
    logic [31:0] a_dout;
    logic [15:0] a_ec;
    logic        corrupt_a = 1'b0;
    logic [31:0] mem_a [256];

    logic        b_start = 1'b0, b_stop = 1'b0;
    logic [1:0]  b_mode  = 2'd0;
    logic [31:0] b_seed  = '0;
    logic        b_busy, b_done, b_wr, b_err;
    logic [15:0] b_ra, b_wa, b_ea;
    logic [31:0] b_din, b_dout, b_d1, b_d2;
    logic [15:0] b_ec;
    logic [15:0] b_bad = 16'hFFFF;
    logic [31:0] mem_b [256];

    mem_sweep_gen u_a (
        .clk(clk), .nrst(nrst), .start(a_start), .stop(a_stop),
        .mode(a_mode), .seed(a_seed), .busy(a_busy), .done(a_done),
        .raddress(a_ra), .waddress(a_wa), .wr(a_wr), .datain(a_din),
        .dataout(a_dout), .err(a_err), .err_count(a_ec),
        .err_addr(a_ea)
    );

    mem_sweep_gen #(
        .AW(16), .DW(32), .BASE(32'h10), .LIMIT(32'h3F),
        .STRIDE(8), .RD_LAT(3)
    ) u_b (
        .clk(clk), .nrst(nrst), .start(b_start), .stop(b_stop),
        .mode(b_mode), .seed(b_seed), .busy(b_busy), .done(b_done),
        .raddress(b_ra), .waddress(b_wa), .wr(b_wr), .datain(b_din),
        .dataout(b_dout), .err(b_err), .err_count(b_ec),
        .err_addr(b_ea)
    );

    always @(posedge clk) begin
        if (a_wr) mem_a[a_wa[7:0]] <= a_din;
        a_dout <= mem_a[a_ra[7:0]] ^
                  ((corrupt_a && (a_ra == 32'h20 || a_ra == 32'h30))
                   ? 32'h1 : 32'h0);
    end

    always @(posedge clk) begin
        if (b_wr) mem_b[b_wa[7:0]] <= b_din;
        b_d1   <= mem_b[b_ra[7:0]] ^ ((b_ra == b_bad) ? 32'h1 : 32'h0);
        b_d2   <= b_d1;
        b_dout <= b_d2;
    end

    task automatic test_reset();
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({a_busy, a_done, a_wr, a_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000",
                     {a_busy, a_done, a_wr, a_err});
        end
        total++;
        if (a_ra !== 32'h0 || a_wa !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr_a got=%h/%h want=0/0", a_ra, a_wa);
        end
        total++;
        if (a_din !== 32'h0 || a_ec !== 16'h0 || a_ea !== 32'h0) begin
            bad++;
            $display("FAIL reset_data_a got=%h/%h/%h want=0/0/0",
                     a_din, a_ec, a_ea);
        end
        total++;
        if (b_ra !== 16'h10 || b_wa !== 16'h10 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_b got=%h/%h/%b want=10/10/0",
                     b_ra, b_wa, b_busy);
        end
        nrst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        wr_t q[$];
        wr_t e;
        int nbusy = 0, ndone = 0, dcyc = 0;
        for (int k = 0; k < 17; k++) begin
            e.a = 32'(k * 4);
            e.d = 32'h1000_0000 + 32'(k * 4);
            q.push_back(e);
        end
        a_mode = 2'd1; a_seed = 32'h1000_0000; a_start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            a_start = (c == 5);
            a_mode  = (c == 5) ? 2'd0 : 2'd1;
            if (a_busy) nbusy++;
            if (a_done) begin ndone++; dcyc = c; end
            if (a_wr) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL fill_extra_write got=%h want=none", a_wa);
                end else begin
                    e = q.pop_front();
                    if (a_wa !== e.a || a_din !== e.d) begin
                        bad++;
                        $display("FAIL fill_write got=%h:%h want=%h:%h",
                                 a_wa, a_din, e.a, e.d);
                    end
                end
            end
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL fill_missing got=%0d want=0", q.size());
        end
        total++;
        if (nbusy != 17 || ndone != 1 || dcyc != 18) begin
            bad++;
            $display("FAIL fill_timing got=%0d/%0d/%0d want=17/1/18",
                     nbusy, ndone, dcyc);
        end
        total++;
        if (a_wr !== 1'b0 || a_wa !== 32'h40) begin
            bad++;
            $display("FAIL fill_after got=%b/%h want=0/40", a_wr, a_wa);
        end
        total++;
        if (mem_a[8'h40] !== 32'h1000_0040) begin
            bad++;
            $display("FAIL fill_mem40 got=%h want=10000040",
                     mem_a[8'h40]);
        end
    endtask

    task automatic test_check(input bit corrupt);
        logic [31:0] q[$];
        logic [31:0] ra;
        int nbusy = 0, ndone = 0, dcyc = 0;
        corrupt_a = corrupt;
        for (int k = 0; k < 17; k++) q.push_back(32'(k * 4));
        a_mode = 2'd2; a_seed = 32'hA5A5_0000; a_start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_busy) nbusy++;
            if (a_done) begin ndone++; dcyc = c; end
            total++;
            if (a_wr !== (c <= 17)) begin
                bad++;
                $display("FAIL check_wr c=%0d got=%b want=%b",
                         c, a_wr, (c <= 17));
            end
            if (c >= 18 && c <= 34) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL check_rd_extra got=%h want=none", a_ra);
                end else begin
                    ra = q.pop_front();
                    if (a_ra !== ra) begin
                        bad++;
                        $display("FAIL check_raddr got=%h want=%h",
                                 a_ra, ra);
                    end
                end
            end
        end
        total++;
        if (nbusy != 35 || ndone != 1 || dcyc != 36) begin
            bad++;
            $display("FAIL check_timing got=%0d/%0d/%0d want=35/1/36",
                     nbusy, ndone, dcyc);
        end
        total++;
        if (a_err !== corrupt ||
            a_ec !== (corrupt ? 16'd2 : 16'd0) ||
            a_ea !== (corrupt ? 32'h20 : 32'h0)) begin
            bad++;
            $display("FAIL check_err got=%b/%0d/%h want=%b/%0d/%h",
                     a_err, a_ec, a_ea, corrupt,
                     corrupt ? 2 : 0, corrupt ? 32'h20 : 32'h0);
        end
        corrupt_a = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        logic [31:0] ra;
        int ndone = 0, nwr = 0;
        for (int k = 0; k < 17; k++) q.push_back(32'(k * 4));
        for (int k = 0; k < 5; k++) q.push_back(32'(k * 4));
        a_mode = 2'd3; a_start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_done) ndone++;
            if (a_wr) nwr++;
            ra = q.pop_front();
            total++;
            if (a_ra !== ra || a_busy !== 1'b1) begin
                bad++;
                $display("FAIL wrap_raddr c=%0d got=%h/%b want=%h/1",
                         c, a_ra, a_busy, ra);
            end
            if (c == 22) a_stop = 1'b1;
        end
        @(negedge clk);
        a_stop = 1'b0;
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap_stop_busy got=%b want=0", a_busy);
        end
        repeat (3) begin
            @(negedge clk);
            if (a_done) ndone++;
        end
        total++;
        if (ndone != 0 || nwr != 0 || a_ra !== 32'h10) begin
            bad++;
            $display("FAIL wrap_after got=%0d/%0d/%h want=0/0/10",
                     ndone, nwr, a_ra);
        end
        a_start = 1'b1; a_stop = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_stop = 1'b0;
        @(negedge clk);
        total++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_stop_wins got=%b/%b want=0/0",
                     a_busy, a_done);
        end
    endtask

    task automatic test_params(input logic [15:0] badaddr);
        wr_t wq[$];
        wr_t e;
        logic [15:0] rq[$];
        logic [15:0] ra;
        bit hit;
        int nbusy = 0, ndone = 0, dcyc = 0;
        hit = (badaddr == 16'h38);
        for (int k = 0; k < 6; k++) begin
            e.a = 32'h10 + 32'(k * 8);
            e.d = 32'h1234_0000 + e.a;
            wq.push_back(e);
            rq.push_back(16'h10 + 16'(k * 8));
        end
        b_bad = badaddr;
        b_mode = 2'd2; b_seed = 32'h1234_0000; b_start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_busy) nbusy++;
            if (b_done) begin ndone++; dcyc = c; end
            if (b_wr) begin
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL par_extra_write got=%h want=none", b_wa);
                end else begin
                    e = wq.pop_front();
                    if (b_wa !== e.a[15:0] || b_din !== e.d) begin
                        bad++;
                        $display("FAIL par_write got=%h:%h want=%h:%h",
                                 b_wa, b_din, e.a[15:0], e.d);
                    end
                end
            end
            if (c >= 7 && c <= 12) begin
                ra = rq.pop_front();
                total++;
                if (b_ra !== ra) begin
                    bad++;
                    $display("FAIL par_raddr got=%h want=%h", b_ra, ra);
                end
            end
        end
        total++;
        if (wq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL par_missing got=%0d/%0d want=0/0",
                     wq.size(), rq.size());
        end
        total++;
        if (nbusy != 15 || ndone != 1 || dcyc != 16) begin
            bad++;
            $display("FAIL par_timing got=%0d/%0d/%0d want=15/1/16",
                     nbusy, ndone, dcyc);
        end
        total++;
        if (b_err !== hit || b_ec !== (hit ? 16'd1 : 16'd0) ||
            b_ea !== (hit ? 16'h38 : 16'h0)) begin
            bad++;
            $display("FAIL par_err got=%b/%0d/%h want=%b/%0d/%h",
                     b_err, b_ec, b_ea, hit, hit ? 1 : 0,
                     hit ? 16'h38 : 16'h0);
        end
        b_bad = 16'hFFFF;
    endtask

    task automatic test_reset_mid();
        logic [31:0] q[$];
        logic [31:0] ra;
        int nbusy = 0, ndone = 0;
        a_mode = 2'd1; a_seed = 32'h5555_0000; a_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            a_start = 1'b0;
        end
        total++;
        if (a_wa !== 32'h14 || a_wr !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_k5 got=%h/%b want=14/1", a_wa, a_wr);
        end
        nrst = 1'b1;
        #1;
        total++;
        if (a_wr !== 1'b0 || a_busy !== 1'b0 ||
            a_ra !== 32'h0 || a_wa !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_now got=%b/%b/%h/%h want=0/0/0/0",
                     a_wr, a_busy, a_ra, a_wa);
        end
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 17; k++) q.push_back(32'(k * 4));
        a_mode = 2'd0; a_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_done) ndone++;
            if (a_busy) begin
                nbusy++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rst_read_extra got=%h want=none", a_ra);
                end else begin
                    ra = q.pop_front();
                    if (a_ra !== ra || a_wr !== 1'b0) begin
                        bad++;
                        $display("FAIL rst_read got=%h/%b want=%h/0",
                                 a_ra, a_wr, ra);
                    end
                end
            end
        end
        total++;
        if (nbusy != 17 || ndone != 1 || q.size() != 0) begin
            bad++;
            $display("FAIL rst_read_end got=%0d/%0d/%0d want=17/1/0",
                     nbusy, ndone, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_check(1'b0);
        test_check(1'b1);
        test_wrap();
        test_params(16'hFFFF);
        test_params(16'h0038);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
